// File: rtl/clock_ctrl_pkg.sv
// Shared constants for the clock set-mode controller: the state encoding,
// the mode output width and the default timing constants.
package clock_ctrl_pkg;

  localparam int MODE_W = 3;

  // Button-driven setting sequence; codes 5-7 are unused.
  typedef enum logic [MODE_W-1:0] {
    RUN     = 3'd0,
    CLK_HR  = 3'd1,
    CLK_MIN = 3'd2,
    ALM_HR  = 3'd3,
    ALM_MIN = 3'd4
  } set_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_REPEAT_DELAY_S  = 1;
  localparam int DEF_TIMEOUT_S       = 15;

  // Successor of a state on a mode press; anything unexpected goes to RUN.
  function automatic set_state_e next_mode(input set_state_e s);
    case (s)
      RUN:     return CLK_HR;
      CLK_HR:  return CLK_MIN;
      CLK_MIN: return ALM_HR;
      ALM_HR:  return ALM_MIN;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, debounced
// level and single-cycle rise/fall strobes registered with the level flip.
module button_debounce
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous pad level into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_q2;
        rise  <= sync_q2;
        fall  <= ~sync_q2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/set_mode_controller.sv
// Set-mode controller: steps RUN -> CLK_HR -> CLK_MIN -> ALM_HR -> ALM_MIN
// on debounced mode presses and issues set_pulse strobes from the increment
// button, with hold-to-repeat driven by tick_1hz / tick_fast.
// Optional feature macro: SET_TIMEOUT_EN (idle timeout back to RUN).
// The FSM state is visible directly on the mode output.
module set_mode_controller
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_S  = DEF_REPEAT_DELAY_S,
  parameter int TIMEOUT_S       = DEF_TIMEOUT_S
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic              tick_fast,
  input  logic              btn_mode,
  input  logic              btn_inc,
  output logic [MODE_W-1:0] mode,
  output logic              set_alarm,
  output logic              set_hours,
  output logic              set_minutes,
  output logic              set_pulse
);

  localparam int HOLD_W = (REPEAT_DELAY_S < 1) ? 1 : $clog2(REPEAT_DELAY_S + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DELAY_S);

  logic mode_level, mode_rise, mode_fall;
  logic inc_level, inc_rise, inc_fall;

  set_state_e        state;
  set_state_e        state_next;
  logic              state_change;
  logic              pulse_next;
  logic              repeat_active;
  logic              timeout_hit;
  logic [HOLD_W-1:0] hold_cnt;
  logic              repeat_block;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_mode),
    .level (mode_level),
    .rise  (mode_rise),
    .fall  (mode_fall)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_inc),
    .level (inc_level),
    .rise  (inc_rise),
    .fall  (inc_fall)
  );

  assign mode = state;

  // Next state and next set_pulse; any state change swallows the strobe.
  always_comb begin
    state_next    = state;
    state_change  = 1'b0;
    pulse_next    = 1'b0;
    repeat_active = inc_level && !repeat_block && (hold_cnt == HOLD_MAX);
    case (state)
      RUN, CLK_HR, CLK_MIN, ALM_HR, ALM_MIN: begin
        if (mode_rise) begin
          state_next = next_mode(state);
        end else if (timeout_hit && state != RUN) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
    state_change = (state_next != state);
    if (!state_change && state != RUN) begin
      pulse_next = inc_rise || (repeat_active && tick_fast);
    end
  end

  // State and all decoded outputs register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      set_pulse   <= 1'b0;
      set_alarm   <= 1'b0;
      set_hours   <= 1'b0;
      set_minutes <= 1'b0;
    end else begin
      state       <= state_next;
      set_pulse   <= pulse_next;
      set_alarm   <= (state_next == ALM_HR)  || (state_next == ALM_MIN);
      set_hours   <= (state_next == CLK_HR)  || (state_next == ALM_HR);
      set_minutes <= (state_next == CLK_MIN) || (state_next == ALM_MIN);
    end
  end

  // Hold timer for auto-repeat; a state change while inc is held blocks
  // repeat until the button is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt     <= '0;
      repeat_block <= 1'b0;
    end else if (state_change) begin
      hold_cnt     <= '0;
      repeat_block <= inc_level;
    end else if (!inc_level) begin
      hold_cnt     <= '0;
      repeat_block <= 1'b0;
    end else if (state != RUN && !repeat_block && tick_1hz && hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

`ifdef SET_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_hit = (idle_cnt == IDLE_LAST);

  // Idle seconds in a set state; any button activity or auto-repeat is not idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state_next == RUN) begin
      idle_cnt <= '0;
    end else if (mode_rise || mode_fall || inc_rise || inc_fall) begin
      idle_cnt <= '0;
    end else if (tick_1hz && !repeat_active && idle_cnt != IDLE_LAST) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  // Without the timeout the set states persist; edge strobes are not needed.
  localparam int unused_timeout_s = TIMEOUT_S;
  logic unused_falls;
  assign unused_falls = mode_fall | inc_fall;
  assign timeout_hit  = 1'b0;
`endif

endmodule

// File: tb/tb_set_mode_controller.sv
// Bench for set_mode_controller: directed scenarios plus random button and
// tick activity, checked every cycle against a behavioural model.
// Build with or without SET_TIMEOUT_EN; the model follows the same macro.
module tb_set_mode_controller;

  localparam int D = 4;
  localparam int R = 1;
  localparam int T = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_fast = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [2:0] mode;
  logic       set_alarm, set_hours, set_minutes, set_pulse;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;

  set_mode_controller #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY_S  (R),
    .TIMEOUT_S       (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .tick_fast   (tick_fast),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .mode        (mode),
    .set_alarm   (set_alarm),
    .set_hours   (set_hours),
    .set_minutes (set_minutes),
    .set_pulse   (set_pulse)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: a synced sample must differ from the accepted level D times in
  // a row to be accepted. Mode is an integer 0..4 stepped modulo 5.
  int m_s1[2], m_s2[2], m_run[2], m_lvl[2], m_rise[2], m_fall[2];
  int m_mode, m_pulse, m_hold, m_block, m_idle;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_s1[i] <= 0; m_s2[i] <= 0; m_run[i] <= 0;
        m_lvl[i] <= 0; m_rise[i] <= 0; m_fall[i] <= 0;
      end
      m_mode <= 0; m_pulse <= 0; m_hold <= 0; m_block <= 0; m_idle <= 0;
    end else begin
      int raw[2];
      int nm, rep, busy;
      raw[0] = int'(btn_mode);
      raw[1] = int'(btn_inc);
      for (int i = 0; i < 2; i++) begin
        m_s1[i] <= raw[i];
        m_s2[i] <= m_s1[i];
        m_rise[i] <= 0;
        m_fall[i] <= 0;
        if (m_s2[i] == m_lvl[i]) m_run[i] <= 0;
        else if (m_run[i] + 1 >= D) begin
          m_lvl[i] <= m_s2[i];
          m_run[i] <= 0;
          m_rise[i] <= (m_s2[i] == 1) ? 1 : 0;
          m_fall[i] <= (m_s2[i] == 0) ? 1 : 0;
        end else m_run[i] <= m_run[i] + 1;
      end
      nm = m_mode;
      if (m_mode > 4) nm = 0;
      else if (m_rise[0] == 1) nm = (m_mode + 1) % 5;
`ifdef SET_TIMEOUT_EN
      else if (m_mode != 0 && m_idle >= T) nm = 0;
`endif
      rep = (m_lvl[1] == 1 && m_block == 0 && m_hold >= R) ? 1 : 0;
      m_pulse <= (nm == m_mode && m_mode != 0 &&
                  (m_rise[1] == 1 || (rep == 1 && tick_fast))) ? 1 : 0;
      m_mode <= nm;
      if (nm != m_mode) begin
        m_hold <= 0; m_block <= m_lvl[1];
      end else if (m_lvl[1] == 0) begin
        m_hold <= 0; m_block <= 0;
      end else if (m_mode != 0 && m_block == 0 && tick_1hz && m_hold < R) begin
        m_hold <= m_hold + 1;
      end
      busy = m_rise[0] + m_fall[0] + m_rise[1] + m_fall[1];
      if (nm == 0) m_idle <= 0;
      else if (busy != 0) m_idle <= 0;
      else if (tick_1hz && rep == 0 && m_idle < T) m_idle <= m_idle + 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("mode", int'(mode), m_mode);
    check("set_alarm", int'(set_alarm), (m_mode == 3 || m_mode == 4) ? 1 : 0);
    check("set_hours", int'(set_hours), (m_mode == 1 || m_mode == 3) ? 1 : 0);
    check("set_minutes", int'(set_minutes), (m_mode == 2 || m_mode == 4) ? 1 : 0);
    check("set_pulse", int'(set_pulse), m_pulse);
    if (set_pulse) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press_mode(input int len);
    btn_mode = 1'b1;
    step(len);
    btn_mode = 1'b0;
    step(12);
  endtask

  task automatic pulse_tick(input int fast);
    if (fast != 0) tick_fast = 1'b1; else tick_1hz = 1'b1;
    step(1);
    tick_fast = 1'b0;
    tick_1hz  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, lat, p0, tk;
    int exp_seq[4];
    exp_seq = '{2, 3, 4, 0};

    step(3);
    check("reset_mode", int'(mode), 0);
    check("reset_pulse", int'(set_pulse), 0);
    check("reset_sets", int'({set_alarm, set_hours, set_minutes}), 0);
    rst_n = 1'b1;
    step(3);

    // 1: latency and full mode cycle
    btn_mode = 1'b1;
    t0 = cyc;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (mode == 3'd1) begin lat = cyc - t0; break; end
    end
    check("mode_latency", lat, 7);
    check("first_set_hours", int'(set_hours), 1);
    check("first_set_alarm", int'(set_alarm), 0);
    step(20 - (cyc - t0));
    btn_mode = 1'b0;
    step(12);
    for (int i = 0; i < 4; i++) begin
      press_mode(20);
      check("mode_cycle", int'(mode), exp_seq[i]);
    end

    // 2: glitchy leading edge, exactly one advance
    for (int g = 0; g < 3; g++) begin
      btn_mode = 1'b1; step(2);
      btn_mode = 1'b0; step(2);
    end
    step(6);
    check("glitch_no_advance", int'(mode), 0);
    btn_mode = 1'b1;
    step(6);
    check("glitch_before_stable", int'(mode), 0);
    step(1);
    check("glitch_one_advance", int'(mode), 1);
    step(13);
    btn_mode = 1'b0;
    step(12);
    check("glitch_final", int'(mode), 1);

    // 3: inc tap in CLK_MIN, then in RUN
    press_mode(20);
    check("in_clk_min", int'(mode), 2);
    p0 = pulse_cnt;
    btn_inc = 1'b1;
    t0 = cyc;
    step(10);
    btn_inc = 1'b0;
    step(12);
    check("tap_pulse_count", pulse_cnt - p0, 1);
    check("tap_pulse_latency", last_pulse_cyc - t0, 7);
    for (int i = 0; i < 3; i++) press_mode(20);
    check("back_in_run", int'(mode), 0);
    p0 = pulse_cnt;
    btn_inc = 1'b1; step(10); btn_inc = 1'b0; step(12);
    check("run_tap_no_pulse", pulse_cnt - p0, 0);

    // 4: hold-to-repeat in ALM_HR, then mode press while held
    for (int i = 0; i < 3; i++) press_mode(20);
    check("in_alm_hr", int'(mode), 3);
    p0 = pulse_cnt;
    btn_inc = 1'b1;
    step(12);
    pulse_tick(0);
    step(2);
    for (int i = 0; i < 5; i++) begin
      tk = cyc;
      pulse_tick(1);
      check("repeat_pulse_timing", last_pulse_cyc, tk + 1);
      step(2);
    end
    check("repeat_pulse_count", pulse_cnt - p0, 6);
    press_mode(20);
    check("moved_alm_min", int'(mode), 4);
    p0 = pulse_cnt;
    pulse_tick(0);
    for (int i = 0; i < 5; i++) begin pulse_tick(1); step(2); end
    check("killed_repeat", pulse_cnt - p0, 0);
    btn_inc = 1'b0;
    step(12);

    // 5: simultaneous mode and inc edges in CLK_HR
    press_mode(20);
    press_mode(20);
    check("in_clk_hr", int'(mode), 1);
    p0 = pulse_cnt;
    btn_mode = 1'b1; btn_inc = 1'b1;
    step(20);
    btn_mode = 1'b0; btn_inc = 1'b0;
    step(12);
    check("aligned_mode", int'(mode), 2);
    check("aligned_no_pulse", pulse_cnt - p0, 0);

    // 6: idle timeout behaviour, then reset mid-repeat
    for (int i = 0; i < 4; i++) press_mode(20);
    check("timeout_start", int'(mode), 1);
    for (int i = 0; i < 3; i++) begin pulse_tick(0); step(1); end
    step(3);
`ifdef SET_TIMEOUT_EN
    check("timeout_mode", int'(mode), 0);
`else
    check("timeout_mode", int'(mode), 1);
`endif
    if (m_mode == 0) press_mode(20);
    btn_inc = 1'b1;
    step(12);
    pulse_tick(0);
    step(1);
    pulse_tick(1);
    check("pre_reset_pulse", int'(set_pulse), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_mode", int'(mode), 0);
    check("reset_async_pulse", int'(set_pulse), 0);
    check("reset_async_sets", int'({set_alarm, set_hours, set_minutes}), 0);
    step(3);
    p0 = pulse_cnt;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin pulse_tick(1); step(2); end
    check("no_pulse_after_reset", pulse_cnt - p0, 0);
    btn_inc = 1'b0;
    step(12);

    // random phase
    begin
      int left_m, left_i;
      left_m = 0; left_i = 0;
      for (int c = 0; c < 4000; c++) begin
        if (left_m == 0) begin
          btn_mode = ($urandom_range(0, 3) == 0) ? ~btn_mode : btn_mode;
          left_m = $urandom_range(1, 30);
        end else left_m--;
        if (left_i == 0) begin
          btn_inc = ~btn_inc;
          left_i = (btn_inc) ? $urandom_range(1, 60) : $urandom_range(1, 25);
        end else left_i--;
        tick_1hz  = ($urandom_range(0, 29) == 0);
        tick_fast = ($urandom_range(0, 4) == 0);
        if (c == 2500) rst_n = 1'b0;
        if (c == 2505) rst_n = 1'b1;
        step(1);
      end
      tick_1hz = 1'b0; tick_fast = 1'b0;
      btn_mode = 1'b0; btn_inc = 1'b0;
      step(20);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
